// File: rtl/iter_multiplier_if.sv
// rtl/iter_multiplier_if.sv - operand and result handshake bundle for iter_multiplier
interface iter_multiplier_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 is_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - multi-cycle signed/unsigned multiplier consuming CHUNK bits of b per cycle
module iter_multiplier #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   iter_multiplier_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int PW = 2 * WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("iter_multiplier: CHUNK must divide WIDTH and lie in 1..WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   logic [PW-1:0]     p_q;
   logic [PW-1:0]     acc_q;
   logic [PW-1:0]     mag_a_q;
   logic [WIDTH-1:0]  mag_b_q;
   logic              neg_q;
   logic [CW-1:0]     cnt_q;

   logic [WIDTH-1:0]  mag_a_in;
   logic [WIDTH-1:0]  mag_b_in;
   logic [PW-1:0]     partial;
   logic [PW-1:0]     acc_d;
   logic [PW-1:0]     p_d;

   // mag_a_q is pre-shifted and mag_b_q consumed from the bottom, so no variable part-selects are needed
   always_comb begin
      mag_a_in = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b_in = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      partial  = mag_a_q * {{(PW-CHUNK){1'b0}}, mag_b_q[CHUNK-1:0]};
      acc_d    = acc_q + partial;
      p_d      = neg_q ? -acc_d : acc_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         p_q         <= '0;
         acc_q       <= '0;
         mag_a_q     <= '0;
         mag_b_q     <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  mag_a_q    <= PW'(mag_a_in);
                  mag_b_q    <= mag_b_in;
                  neg_q      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               acc_q   <= acc_d;
               mag_a_q <= mag_a_q << CHUNK;
               mag_b_q <= mag_b_q >> CHUNK;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  p_q         <= p_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.p         = p_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_iter_multiplier.sv
// tb/tb_iter_multiplier.sv - directed and swept checks for iter_multiplier
module tb_iter_multiplier;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   iter_multiplier_if #(.WIDTH(16)) mif ();
   iter_multiplier #(.WIDTH(16), .CHUNK(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));

   logic        sw_in_valid;
   logic [15:0] sw_a;
   logic [15:0] sw_b;
   logic        sw_is_signed;
   logic        sw_out_ready;
   logic [4:0]  sw_ov;
   logic [4:0]  sw_rdy;
   logic [31:0] sw_p [5];

   for (genvar k = 0; k < 5; k++) begin : g_sw
      iter_multiplier_if #(.WIDTH(16)) sif ();
      assign sif.in_valid  = sw_in_valid;
      assign sif.a         = sw_a;
      assign sif.b         = sw_b;
      assign sif.is_signed = sw_is_signed;
      assign sif.out_ready = sw_out_ready;
      assign sw_ov[k]      = sif.out_valid;
      assign sw_rdy[k]     = sif.in_ready;
      assign sw_p[k]       = sif.p;
      iter_multiplier #(.WIDTH(16), .CHUNK(1 << k)) u_sw (.clk(clk), .rst_n(rst_n), .bus(sif.slave));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vs);
      int w;
      w = 0;
      while (!mif.in_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (mif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready got %b want 1", mif.in_ready);
      end
      mif.in_valid  = 1'b1;
      mif.a         = va;
      mif.b         = vb;
      mif.is_signed = vs;
      @(posedge clk); #1;
      mif.in_valid  = 1'b0;
   endtask

   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         output logic [31:0] pr, output int lat);
      mif.out_ready = 1'b1;
      start_op(va, vb, vs);
      lat = -1;
      pr  = '0;
      for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
         @(posedge clk); #1;
         if (mif.out_valid) begin
            lat = cyc;
            pr  = mif.p;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", mif.in_ready); end
      checks++; if (mif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", mif.out_valid); end
      checks++; if (mif.p !== 32'h0) begin errors++; $display("FAIL reset_p got %h want 00000000", mif.p); end
      checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.busy); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (mif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", mif.in_ready); end
   endtask

   task automatic test_unsigned_max();
      mif.out_ready = 1'b1;
      start_op(16'hFFFF, 16'hFFFF, 1'b0);
      checks++; if (mif.busy !== 1'b1 || mif.in_ready !== 1'b0) begin errors++; $display("FAIL umax_busy busy=%b ready=%b want 1/0", mif.busy, mif.in_ready); end
      checks++; if (mif.out_valid !== 1'b0) begin errors++; $display("FAIL umax_early_valid got %b want 0", mif.out_valid); end
      @(posedge clk); #1;
      checks++; if (mif.out_valid !== 1'b0) begin errors++; $display("FAIL umax_valid_t1 got %b want 0", mif.out_valid); end
      @(posedge clk); #1;
      checks++; if (mif.out_valid !== 1'b1) begin errors++; $display("FAIL umax_valid_t2 got %b want 1", mif.out_valid); end
      checks++; if (mif.p !== 32'hFFFE0001) begin errors++; $display("FAIL umax_p got %h want fffe0001", mif.p); end
      @(posedge clk); #1;
      checks++; if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1 || mif.busy !== 1'b0) begin
         errors++; $display("FAIL umax_return valid=%b ready=%b busy=%b want 0/1/0", mif.out_valid, mif.in_ready, mif.busy);
      end
   endtask

   task automatic test_signed_corners();
      logic [15:0] ta [5];
      logic [15:0] tb_v [5];
      logic        ts [5];
      logic [31:0] te [5];
      logic [31:0] pr;
      int          lat;
      ta   = '{16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF};
      tb_v = '{16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 16'h0000};
      ts   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      te   = '{32'h00000001, 32'h40000000, 32'hFFFF8000, 32'hC0008000, 32'h00000000};
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb_v[i], ts[i], pr, lat);
         checks++; if (pr !== te[i]) begin errors++; $display("FAIL corner_p[%0d] got %h want %h", i, pr, te[i]); end
         checks++; if (lat != 2) begin errors++; $display("FAIL corner_latency[%0d] got %0d want 2", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      mif.out_ready = 1'b0;
      start_op(16'h0003, 16'h0005, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mif.out_valid !== 1'b1 || mif.p !== 32'd15) begin errors++; $display("FAIL bp_first valid=%b p=%h want 1/0000000f", mif.out_valid, mif.p); end
      mif.in_valid = 1'b1;
      mif.a        = 16'h0100;
      mif.b        = 16'h0200;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++; if (mif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", c, mif.out_valid); end
         checks++; if (mif.p !== 32'd15) begin errors++; $display("FAIL bp_p[%0d] got %h want 0000000f", c, mif.p); end
         checks++; if (mif.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", c, mif.in_ready); end
      end
      mif.in_valid  = 1'b0;
      mif.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b ready=%b want 0/1", mif.out_valid, mif.in_ready); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mif.out_valid !== 1'b0 || mif.busy !== 1'b0) begin errors++; $display("FAIL bp_not_queued valid=%b busy=%b want 0/0", mif.out_valid, mif.busy); end
   endtask

   task automatic test_operand_hold();
      int lat;
      mif.out_ready = 1'b1;
      start_op(16'h1234, 16'h5678, 1'b0);
      mif.a         = 16'hFFFF;
      mif.b         = 16'h8001;
      mif.is_signed = 1'b1;
      lat = -1;
      for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
         @(posedge clk); #1;
         if (mif.out_valid) begin
            lat = cyc;
            checks++; if (mif.p !== 32'h06260060) begin errors++; $display("FAIL hold_p got %h want 06260060", mif.p); end
         end
      end
      checks++; if (lat != 2) begin errors++; $display("FAIL hold_latency got %0d want 2", lat); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_calc();
      mif.out_ready = 1'b1;
      start_op(16'h00FF, 16'h00FF, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (mif.in_ready !== 1'b1 || mif.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ready ready=%b busy=%b want 1/0", mif.in_ready, mif.busy); end
      for (int c = 0; c < 5; c++) begin
         checks++; if (mif.out_valid !== 1'b0 || mif.p !== 32'h0) begin errors++; $display("FAIL rst_mid_out[%0d] valid=%b p=%h want 0/00000000", c, mif.out_valid, mif.p); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int hits [$];
      mif.out_ready = 1'b1;
      mif.in_valid  = 1'b1;
      mif.a         = 16'd7;
      mif.b         = 16'd9;
      mif.is_signed = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge clk); #1;
         if (mif.out_valid) begin
            hits.push_back(cyc);
            checks++; if (mif.p !== 32'd63) begin errors++; $display("FAIL b2b_p at %0d got %h want 0000003f", cyc, mif.p); end
         end
      end
      mif.in_valid = 1'b0;
      checks++; if (hits.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", hits.size()); end
      else begin
         checks++; if (hits[0] != 3 || hits[1] != 7 || hits[2] != 11) begin
            errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 3,7,11", hits[0], hits[1], hits[2]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_param_sweep();
      int                 lat [5];
      int                 w;
      int                 done_n;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        exp_p;
      logic [15:0]        va;
      logic [15:0]        vb;
      logic               vs;
      sw_out_ready = 1'b1;
      for (int v = 0; v < 1000; v++) begin
         va = 16'($urandom);
         vb = 16'($urandom);
         vs = 1'($urandom_range(0, 1));
         if (v == 0) begin va = 16'h8000; vb = 16'h8000; vs = 1'b1; end
         if (v == 1) begin va = 16'hFFFF; vb = 16'hFFFF; vs = 1'b0; end
         if (v == 2) begin va = 16'h0000; vb = 16'h8000; vs = 1'b1; end
         if (vs) begin
            sa    = $signed(va);
            sb    = $signed(vb);
            exp_p = sa * sb;
         end else begin
            exp_p = {16'h0, va} * {16'h0, vb};
         end
         w = 0;
         while (sw_rdy != 5'h1F && w < 40) begin
            @(posedge clk); #1;
            w++;
         end
         checks++;
         if (sw_rdy != 5'h1F) begin errors++; $display("FAIL sweep_ready vec %0d got %b want 11111", v, sw_rdy); end
         sw_a         = va;
         sw_b         = vb;
         sw_is_signed = vs;
         sw_in_valid  = 1'b1;
         @(posedge clk); #1;
         sw_in_valid  = 1'b0;
         for (int k = 0; k < 5; k++) lat[k] = -1;
         done_n = 0;
         for (int cyc = 1; cyc <= 20 && done_n < 5; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) begin
               if (sw_ov[k] && lat[k] < 0) begin
                  lat[k] = cyc;
                  done_n++;
                  checks++;
                  if (sw_p[k] !== exp_p) begin
                     errors++; $display("FAIL sweep_p chunk %0d vec %0d a=%h b=%h s=%b got %h want %h", 1 << k, v, va, vb, vs, sw_p[k], exp_p);
                  end
               end
            end
         end
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (lat[k] != (16 >> k)) begin errors++; $display("FAIL sweep_latency chunk %0d vec %0d got %0d want %0d", 1 << k, v, lat[k], 16 >> k); end
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      mif.in_valid  = 1'b0;
      mif.a         = '0;
      mif.b         = '0;
      mif.is_signed = 1'b0;
      mif.out_ready = 1'b0;
      sw_in_valid   = 1'b0;
      sw_a          = '0;
      sw_b          = '0;
      sw_is_signed  = 1'b0;
      sw_out_ready  = 1'b0;
      test_reset();
      test_unsigned_max();
      test_signed_corners();
      test_backpressure();
      test_operand_hold();
      test_reset_mid_calc();
      test_back_to_back();
      test_param_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
